// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
//
// Two-pin serial test access path for a wide-port core. A vector is shifted in
// on s_in (one position per s_valid cycle), applied to the core in one parallel
// update, the core is left to run for RUN_CYCLES clocks, its outputs are
// captured in parallel, and they leave on s_out during the following scan.
//
// Parameters
//   IN_WIDTH   : width of dut_in (bits driven onto the core), >= 1
//   OUT_WIDTH  : width of dut_out (bits captured from the core), >= 1
//   RUN_CYCLES : clocks between update and capture, >= 0
//
// Ports
//   clk      in   single clock, rising edge
//   aresetn  in   synchronous active-low reset
//   start    in   begin a scan/update/run/capture sequence (sampled in IDLE)
//   s_in     in   serial data in
//   s_valid  in   serial bit available; advances the chain one position in SHIFT
//   s_out    out  serial data out, MSB of the chain
//   dut_in   out  registered parallel vector to the core
//   dut_out  in   parallel core outputs, sampled in CAPTURE
//   busy     out  high whenever the sequencer is not IDLE
//   done     out  one-cycle pulse in the cycle after CAPTURE
// -----------------------------------------------------------------------------
module scan_chain_ctrl #(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 48,
  parameter int RUN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 s_in,
  input  logic                 s_valid,
  output logic                 s_out,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 busy,
  output logic                 done
);

  localparam int L  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int CW = $clog2(L + 1);
  // A zero-cycle run still needs a legal (unused) counter width.
  localparam int RW = (RUN_CYCLES > 0) ? $clog2(RUN_CYCLES + 1) : 1;

  localparam logic [CW-1:0] SHIFT_LAST = CW'(L - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_UPDATE,
    S_RUN,
    S_CAPTURE
  } state_t;

  state_t          state;
  logic [L-1:0]    sr;
  logic [L-1:0]    sr_shifted;
  logic [L-1:0]    sr_capture;
  logic [CW-1:0]   shift_cnt;
  logic [RW-1:0]   run_cnt;

  // Shift toward the MSB; written as shift-then-insert so L == 1 needs no
  // special case. The capture image zero-fills the chain above OUT_WIDTH so
  // the first L-OUT_WIDTH bits of the next scan are 0.
  always_comb begin
    sr_shifted    = sr << 1;
    sr_shifted[0] = s_in;
    sr_capture    = '0;
    sr_capture[OUT_WIDTH-1:0] = dut_out;
  end

  assign s_out = sr[L-1];
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      sr        <= '0;
      dut_in    <= '0;
      shift_cnt <= '0;
      run_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SHIFT;
            shift_cnt <= '0;
          end
        end

        // Stalled cycles (s_valid low) hold chain, counter and s_out.
        S_SHIFT: begin
          if (s_valid) begin
            sr        <= sr_shifted;
            shift_cnt <= shift_cnt + 1'b1;
            if (shift_cnt == SHIFT_LAST) begin
              state <= S_UPDATE;
            end
          end
        end

        // The only place dut_in changes, so core inputs are quiet while shifting.
        S_UPDATE: begin
          dut_in  <= sr[IN_WIDTH-1:0];
          run_cnt <= '0;
          state   <= (RUN_CYCLES > 0) ? S_RUN : S_CAPTURE;
        end

        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (run_cnt == RUN_LAST) begin
            state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          sr    <= sr_capture;
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
//
// Two instances: A (IN=8, OUT=4, RUN=2) and B (IN=4, OUT=8, RUN=0); both L=8.
// The driver issues directed scans and pushes the expected serial-out bits and
// the expected done cycle / dut_in value into queues; a monitor on the falling
// edge pops and compares whenever s_out is being presented or done pulses.
// Done is expected at the edge E+L+2+R (plus stall cycles) after the start edge E.
// -----------------------------------------------------------------------------
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] aresetn, start, s_in, s_valid, so_chk;
  logic       s_out_a, s_out_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] dut_in_a;
  logic [3:0] dut_in_b;
  logic [3:0] dut_out_a;
  logic [7:0] dut_out_b;

  scan_chain_ctrl #(.IN_WIDTH(8), .OUT_WIDTH(4), .RUN_CYCLES(2)) dut_a (
    .clk(clk), .aresetn(aresetn[0]), .start(start[0]), .s_in(s_in[0]),
    .s_valid(s_valid[0]), .s_out(s_out_a), .dut_in(dut_in_a),
    .dut_out(dut_out_a), .busy(busy_a), .done(done_a)
  );

  scan_chain_ctrl #(.IN_WIDTH(4), .OUT_WIDTH(8), .RUN_CYCLES(0)) dut_b (
    .clk(clk), .aresetn(aresetn[1]), .start(start[1]), .s_in(s_in[1]),
    .s_valid(s_valid[1]), .s_out(s_out_b), .dut_in(dut_in_b),
    .dut_out(dut_out_b), .busy(busy_b), .done(done_b)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Expected chain contents and last applied dut_in, per instance.
  logic [7:0] mdl     [2];
  logic [7:0] mdl_din [2];

  logic       soq0 [$];
  logic       soq1 [$];
  int         dq0_cyc [$];
  int         dq1_cyc [$];
  logic [7:0] dq0_din [$];
  logic [7:0] dq1_din [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] din(input int i);
    return (i == 0) ? dut_in_a : {4'b0, dut_in_b};
  endfunction

  function automatic logic done_of(input int i);
    return (i == 0) ? done_a : done_b;
  endfunction

  task automatic push_so(input int i, input logic b);
    if (i == 0) soq0.push_back(b);
    else        soq1.push_back(b);
    so_chk[i] = 1'b1;
  endtask

  task automatic push_done(input int i, input int c, input logic [7:0] d);
    if (i == 0) begin dq0_cyc.push_back(c); dq0_din.push_back(d); end
    else        begin dq1_cyc.push_back(c); dq1_din.push_back(d); end
  endtask

  // Monitor: serial output while a scan is presented, and done responses.
  always @(negedge clk) begin
    if (so_chk[0]) begin
      if (soq0.size() == 0) chk("s_out_a_unexpected", 1, 0);
      else chk("s_out_a", 32'(s_out_a), 32'(soq0.pop_front()));
    end
    if (so_chk[1]) begin
      if (soq1.size() == 0) chk("s_out_b_unexpected", 1, 0);
      else chk("s_out_b", 32'(s_out_b), 32'(soq1.pop_front()));
    end
    if (done_a) begin
      if (dq0_cyc.size() == 0) chk("done_a_unexpected", 1, 0);
      else begin
        chk("done_a_cycle", 32'(cyc), 32'(dq0_cyc.pop_front()));
        chk("dut_in_a", 32'(dut_in_a), 32'(dq0_din.pop_front()));
        chk("busy_a_with_done", 32'(busy_a), 0);
      end
    end
    if (done_b) begin
      if (dq1_cyc.size() == 0) chk("done_b_unexpected", 1, 0);
      else begin
        chk("done_b_cycle", 32'(cyc), 32'(dq1_cyc.pop_front()));
        chk("dut_in_b", 32'(dut_in_b), 32'(dq1_din.pop_front()));
        chk("busy_b_with_done", 32'(busy_b), 0);
      end
    end
  end

  // One full scan on instance i, shifting bits MSB first. stall inserts an
  // s_valid=0 cycle before every bit but the first; hold keeps start high.
  task automatic seq(input int i, input logic [7:0] bits, input bit stall,
                     input bit hold, input logic [7:0] exp_din);
    int e;
    int ns;
    bit seen;
    start[i] = 1'b1;
    @(posedge clk); #1;
    e  = cyc;
    ns = 0;
    if (!hold) start[i] = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (stall && k < 7) begin
        s_valid[i] = 1'b0;
        push_so(i, mdl[i][7]);
        @(posedge clk); #1;
        ns++;
      end
      s_valid[i] = 1'b1;
      s_in[i]    = bits[k];
      push_so(i, mdl[i][7]);
      if (k == 4) chk((i == 0) ? "dut_in_hold_a" : "dut_in_hold_b", 32'(din(i)), 32'(mdl_din[i]));
      mdl[i] = {mdl[i][6:0], bits[k]};
      @(posedge clk); #1;
    end
    s_valid[i] = 1'b0;
    so_chk[i]  = 1'b0;
    push_done(i, e + 10 + ((i == 0) ? 2 : 0) + ns, exp_din);
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      if (done_of(i)) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) chk("done_timeout", 0, 1);
    mdl[i]     = (i == 0) ? {4'b0, dut_out_a} : dut_out_b;
    mdl_din[i] = exp_din;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy_a"},   32'(busy_a),   0);
    chk({tag, "_done_a"},   32'(done_a),   0);
    chk({tag, "_s_out_a"},  32'(s_out_a),  0);
    chk({tag, "_dut_in_a"}, 32'(dut_in_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 2'b00; start = 2'b11; s_in = 2'b11; s_valid = 2'b11; so_chk = 2'b00;
    dut_out_a = 4'hA; dut_out_b = 8'h5B;
    mdl[0] = '0; mdl[1] = '0; mdl_din[0] = '0; mdl_din[1] = '0;

    // Reset held two cycles with start/s_in/s_valid high: nothing moves.
    @(posedge clk); #1;
    reset_checks("rst1");
    @(posedge clk); #1;
    reset_checks("rst2");
    chk("rst_busy_b",   32'(busy_b),   0);
    chk("rst_s_out_b",  32'(s_out_b),  0);
    chk("rst_dut_in_b", 32'(dut_in_b), 0);
    start = 2'b00; s_in = 2'b00; s_valid = 2'b00;
    aresetn = 2'b11;
    idle(2);

    // Basic scan, then stalled scan (s_out shows captured 4'hA), then new data.
    seq(0, 8'hC5, 1'b0, 1'b0, 8'hC5);
    idle(2);
    seq(0, 8'hC5, 1'b1, 1'b0, 8'hC5);
    idle(1);
    seq(0, 8'h3A, 1'b0, 1'b0, 8'h3A);
    idle(2);

    // Abort after three accepted shifts.
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid[0] = 1'b1; s_in[0] = 1'b1;
      push_so(0, mdl[0][7]);
      mdl[0] = {mdl[0][6:0], 1'b1};
      @(posedge clk); #1;
    end
    s_valid[0] = 1'b0; so_chk[0] = 1'b0;
    aresetn[0] = 1'b0;
    @(posedge clk); #1;
    reset_checks("abort");
    aresetn[0] = 1'b1;
    mdl[0] = '0; mdl_din[0] = '0;
    idle(1);
    seq(0, 8'h96, 1'b0, 1'b0, 8'h96);
    idle(2);

    // Back-to-back with start held high throughout.
    dut_out_a = 4'h6;
    seq(0, 8'h5E, 1'b0, 1'b1, 8'h5E);
    seq(0, 8'hA1, 1'b0, 1'b0, 8'hA1);
    idle(2);

    // Instance B: RUN_CYCLES=0, only the last four shifted bits reach dut_in.
    seq(1, 8'hB6, 1'b0, 1'b0, 8'h06);
    idle(2);
    seq(1, 8'hF1, 1'b0, 1'b0, 8'h01);
    idle(4);

    chk("pending_done_a", 32'(dq0_cyc.size()), 0);
    chk("pending_done_b", 32'(dq1_cyc.size()), 0);
    chk("pending_s_out_a", 32'(soq0.size()), 0);
    chk("pending_s_out_b", 32'(soq1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
